// File: rtl/bp_cac_pkg.sv
// Shared types and helpers for the accelerator-socket fan-out bridge.
package bp_cac_pkg;

  typedef enum logic [1:0] {
    e_cac_br_empty = 2'd0,
    e_cac_br_hold  = 2'd1,
    e_cac_br_err   = 2'd2
  } cac_br_state_e;

  // One bit of a locally generated error response: the command bit, with the
  // error flag position forced high.
  function automatic logic cac_err_resp_bit(input logic        cmd_bit,
                                            input int unsigned pos,
                                            input int unsigned err_bit);
    return cmd_bit | (pos == err_bit);
  endfunction

endpackage

// File: rtl/bp_cac_rr_arb.sv
// Combinational N-way round-robin arbiter; override suppresses every grant so
// an external requester (the local error slot) can take the cycle.
module bp_cac_rr_arb
  import bp_cac_pkg::*;
#(
  parameter int num_p = 4,
  parameter int idx_w = (num_p > 1) ? $clog2(num_p) : 1
) (
  input  logic [num_p-1:0] req,
  input  logic [idx_w-1:0] ptr,
  input  logic             override,
  output logic [num_p-1:0] grant
);

  logic found;
  int   idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    if (!override) begin
      for (int i = 0; i < num_p; i++) begin
        idx = (int'(ptr) + i) % num_p;
        if (!found && req[idx]) begin
          grant[idx] = 1'b1;
          found      = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/bp_cac_multi_io_bridge.sv
// Fans socket IO commands out to num_accel_p accelerators by address select and
// merges their responses back round-robin, with per-channel in-flight limits.
module bp_cac_multi_io_bridge
  import bp_cac_pkg::*;
#(
  parameter int num_accel_p       = 4,
  parameter int cmd_width_p       = 128,
  parameter int resp_width_p      = 128,
  parameter int sel_lsb_p         = 20,
  parameter int sel_width_p       = 4,
  parameter int max_outstanding_p = 4,
  parameter int err_bit_p         = 0,
  localparam int cnt_w            = $clog2(max_outstanding_p + 1)
) (
  input  logic                                clk_i,
  input  logic                                reset_n_i,
  input  logic [cmd_width_p-1:0]              io_cmd_i,
  input  logic                                io_cmd_v_i,
  output logic                                io_cmd_ready_o,
  output logic [resp_width_p-1:0]             io_resp_o,
  output logic                                io_resp_v_o,
  input  logic                                io_resp_yumi_i,
  output logic [num_accel_p*cmd_width_p-1:0]  acc_cmd_o,
  output logic [num_accel_p-1:0]              acc_cmd_v_o,
  input  logic [num_accel_p-1:0]              acc_cmd_ready_i,
  input  logic [num_accel_p*resp_width_p-1:0] acc_resp_i,
  input  logic [num_accel_p-1:0]              acc_resp_v_i,
  output logic [num_accel_p-1:0]              acc_resp_yumi_o,
  output logic [num_accel_p*cnt_w-1:0]        outstanding_o
);

  localparam int idx_w = (num_accel_p > 1) ? $clog2(num_accel_p) : 1;

  cac_br_state_e           state_r, state_n;
  logic [cmd_width_p-1:0]  cmd_p0;
  logic [sel_width_p-1:0]  sel_p0, sel_in;
  logic [cnt_w-1:0]        cnt_r [num_accel_p];
  logic [cnt_w-1:0]        cnt_sel;
  logic [idx_w-1:0]        rr_r, rr_n;
  logic [num_accel_p-1:0]  sel_oh, grant, inc, dec;
  logic [resp_width_p-1:0] err_resp, win_resp;
  logic                    sel_in_ok, hold_v, dispatch, accept, err_pend;

  assign sel_in    = io_cmd_i[sel_lsb_p +: sel_width_p];
  assign sel_in_ok = int'(sel_in) < num_accel_p;

  always_comb begin
    sel_oh  = '0;
    cnt_sel = '0;
    for (int g = 0; g < num_accel_p; g++) begin
      if (int'(sel_p0) == g) begin
        sel_oh[g] = 1'b1;
        cnt_sel   = cnt_r[g];
      end
    end
  end

  // Buffer FSM outputs; everything handshake-related is held low in reset.
  always_comb begin
    hold_v         = reset_n_i && (state_r == e_cac_br_hold) &&
                     (int'(cnt_sel) < max_outstanding_p);
    dispatch       = hold_v && |(sel_oh & acc_cmd_ready_i);
    acc_cmd_v_o    = hold_v ? sel_oh : '0;
    io_cmd_ready_o = reset_n_i && ((state_r == e_cac_br_empty) || dispatch);
    err_pend       = reset_n_i && (state_r == e_cac_br_err);
  end

  assign accept = io_cmd_v_i && io_cmd_ready_o;

  always_comb begin
    state_n = state_r;
    unique case (state_r)
      e_cac_br_empty, e_cac_br_hold: begin
        if (accept)        state_n = sel_in_ok ? e_cac_br_hold : e_cac_br_err;
        else if (dispatch) state_n = e_cac_br_empty;
      end
      e_cac_br_err:    if (io_resp_yumi_i) state_n = e_cac_br_empty;
      default:         state_n = e_cac_br_empty;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) state_r <= e_cac_br_empty;
    else            state_r <= state_n;
  end

  // Stage p0: the one-entry command buffer (data only, validity lives in state_r).
  always_ff @(posedge clk_i) begin
    if (accept) begin
      cmd_p0 <= io_cmd_i;
      sel_p0 <= sel_in;
    end
  end

  assign acc_cmd_o = {num_accel_p{cmd_p0}};

  always_comb begin
    err_resp = '0;
    for (int b = 0; b < resp_width_p; b++)
      err_resp[b] = cac_err_resp_bit(cmd_p0[b], b, err_bit_p);
  end

  bp_cac_rr_arb #(
    .num_p    (num_accel_p),
    .idx_w    (idx_w)
  ) u_arb (
    .req      (acc_resp_v_i),
    .ptr      (rr_r),
    .override (err_pend),
    .grant    (grant)
  );

  always_comb begin
    win_resp = '0;
    for (int g = 0; g < num_accel_p; g++)
      if (grant[g]) win_resp = acc_resp_i[g*resp_width_p +: resp_width_p];
  end

  assign io_resp_o       = err_pend ? err_resp : win_resp;
  assign io_resp_v_o     = reset_n_i && (err_pend || (|acc_resp_v_i));
  assign acc_resp_yumi_o = (reset_n_i && io_resp_yumi_i && !err_pend) ? grant : '0;

  always_comb begin
    rr_n = rr_r;
    for (int g = 0; g < num_accel_p; g++)
      if (acc_resp_yumi_o[g]) rr_n = idx_w'((g + 1) % num_accel_p);
  end

  assign inc = dispatch ? sel_oh : '0;
  assign dec = acc_resp_yumi_o;

  // Counters saturate in hardware; the illegal cases are flagged below.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      rr_r <= '0;
      for (int g = 0; g < num_accel_p; g++) cnt_r[g] <= '0;
    end else begin
      rr_r <= rr_n;
      for (int g = 0; g < num_accel_p; g++) begin
        if (inc[g] && !dec[g] && (int'(cnt_r[g]) < max_outstanding_p))
          cnt_r[g] <= cnt_r[g] + 1'b1;
        else if (dec[g] && !inc[g] && (cnt_r[g] != '0))
          cnt_r[g] <= cnt_r[g] - 1'b1;
      end
    end
  end

  for (genvar g = 0; g < num_accel_p; g++) begin : g_out
    assign outstanding_o[g*cnt_w +: cnt_w] = cnt_r[g];

    a_no_underflow: assert property (@(posedge clk_i) disable iff (!reset_n_i)
      !(dec[g] && !inc[g] && (cnt_r[g] == '0)));
    a_no_overflow: assert property (@(posedge clk_i) disable iff (!reset_n_i)
      !(inc[g] && !dec[g] && (int'(cnt_r[g]) >= max_outstanding_p)));
  end

  a_yumi_needs_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    !(io_resp_yumi_i && !io_resp_v_o));

endmodule

// File: tb/tb_bp_cac_multi_io_bridge.sv
// Self-checking bench for bp_cac_multi_io_bridge: directed vector table,
// hand-written corner sequences and a randomized run against a behavioural model.
module tb_bp_cac_multi_io_bridge;

  localparam int N    = 4;
  localparam int CW   = 128;
  localparam int RW   = 128;
  localparam int SL   = 20;
  localparam int SW   = 4;
  localparam int MAX  = 4;
  localparam int EB   = 0;
  localparam int CNTW = 3;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [CW-1:0]   io_cmd;
  logic            io_cmd_v, io_cmd_ready;
  logic [RW-1:0]   io_resp;
  logic            io_resp_v, io_resp_yumi;
  logic [N*CW-1:0] acc_cmd;
  logic [N-1:0]    acc_cmd_v, acc_cmd_ready;
  logic [N*RW-1:0] acc_resp;
  logic [N-1:0]    acc_resp_v, acc_resp_yumi;
  logic [N*CNTW-1:0] outstanding;

  int checks = 0;
  int errors = 0;

  // behavioural model state
  bit            mv, merr;
  int            msel, mrr;
  logic [CW-1:0] mcmd;
  int            mcnt [N];

  always #5 clk = ~clk;

  bp_cac_multi_io_bridge #(
    .num_accel_p(N), .cmd_width_p(CW), .resp_width_p(RW), .sel_lsb_p(SL),
    .sel_width_p(SW), .max_outstanding_p(MAX), .err_bit_p(EB)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .io_cmd_i(io_cmd), .io_cmd_v_i(io_cmd_v), .io_cmd_ready_o(io_cmd_ready),
    .io_resp_o(io_resp), .io_resp_v_o(io_resp_v), .io_resp_yumi_i(io_resp_yumi),
    .acc_cmd_o(acc_cmd), .acc_cmd_v_o(acc_cmd_v), .acc_cmd_ready_i(acc_cmd_ready),
    .acc_resp_i(acc_resp), .acc_resp_v_i(acc_resp_v), .acc_resp_yumi_o(acc_resp_yumi),
    .outstanding_o(outstanding)
  );

  typedef struct {
    logic       cmd_v;
    logic [3:0] sel;
    logic [7:0] low;
    logic [3:0] ardy;
    logic [3:0] rv;
    logic       yumi;
    logic       e_ready;
    logic [3:0] e_accv;
    logic       e_rv;
    logic [3:0] e_yumi;
    logic [7:0] e_low;
    logic [11:0] e_out;
  } vec_t;

  vec_t tbl [17];

  task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [CW-1:0] mk_cmd(input logic [3:0] sel, input logic [7:0] low);
    logic [CW-1:0] c;
    c = {$urandom, $urandom, $urandom, $urandom};
    c[SL +: SW] = sel;
    c[7:0] = low;
    return c;
  endfunction

  task automatic set_fixed_resp();
    for (int g = 0; g < N; g++)
      acc_resp[g*RW +: RW] = {$urandom, $urandom, $urandom, $urandom[23:0], 8'((g + 1) * 16)};
  endtask

  task automatic do_reset();
    reset_n = 1'b0; io_cmd_v = 1'b0; io_resp_yumi = 1'b0;
    acc_cmd_ready = '1; acc_resp_v = '0;
    step();
    reset_n = 1'b1;
  endtask

  function automatic logic [2:0] cnt_of(input int g);
    return outstanding[g*CNTW +: CNTW];
  endfunction

  task automatic run_random(input int cycles);
    bit            disp, accept;
    logic [N-1:0]  e_accv, e_yumi;
    logic          e_ready, e_rv;
    logic [RW-1:0] e_resp;
    logic [N*CNTW-1:0] e_out;
    logic [3:0]    sel;
    int            win, g;
    mv = 1'b0; merr = 1'b0; msel = 0; mrr = 0; mcmd = '0;
    for (int k = 0; k < N; k++) mcnt[k] = 0;
    for (int c = 0; c < cycles; c++) begin
      io_cmd_v = 1'($urandom_range(0, 1));
      sel = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
      io_cmd = mk_cmd(sel, 8'($urandom));
      acc_cmd_ready = 4'($urandom);
      for (int k = 0; k < N; k++) begin
        acc_resp[k*RW +: RW] = {$urandom, $urandom, $urandom, $urandom};
        acc_resp_v[k] = (mcnt[k] > 0) &&
                        ((c < cycles / 2) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0));
      end
      disp = 1'b0; e_accv = '0;
      if (mv && !merr && mcnt[msel] < MAX) begin
        e_accv[msel] = 1'b1;
        disp = acc_cmd_ready[msel];
      end
      e_ready = !mv || disp;
      e_rv = merr || (acc_resp_v != '0);
      win = -1;
      if (!merr)
        for (int k = 0; k < N; k++) begin
          g = (mrr + k) % N;
          if (win < 0 && acc_resp_v[g]) win = g;
        end
      e_resp = merr ? (mcmd[RW-1:0] | (RW'(1) << EB)) : ((win >= 0) ? acc_resp[win*RW +: RW] : '0);
      io_resp_yumi = e_rv && ($urandom_range(0, 2) != 0);
      e_yumi = (io_resp_yumi && !merr && win >= 0) ? (4'b1 << win) : 4'b0;
      for (int k = 0; k < N; k++) e_out[k*CNTW +: CNTW] = 3'(mcnt[k]);
      #1;
      check($sformatf("rnd%0d ready", c), CW'(io_cmd_ready), CW'(e_ready));
      check($sformatf("rnd%0d acc_v", c), CW'(acc_cmd_v), CW'(e_accv));
      check($sformatf("rnd%0d resp_v", c), CW'(io_resp_v), CW'(e_rv));
      check($sformatf("rnd%0d acc_yumi", c), CW'(acc_resp_yumi), CW'(e_yumi));
      check($sformatf("rnd%0d outstanding", c), CW'(outstanding), CW'(e_out));
      if (e_rv) check($sformatf("rnd%0d resp", c), CW'(io_resp), CW'(e_resp));
      if (e_accv != '0) check($sformatf("rnd%0d acc_cmd", c), acc_cmd[msel*CW +: CW], mcmd);
      if (disp) mcnt[msel]++;
      if (e_yumi != '0) begin
        mcnt[win]--;
        mrr = (win + 1) % N;
      end
      accept = io_cmd_v && e_ready;
      if (accept) begin
        mv = 1'b1; merr = (sel >= N); msel = int'(sel); mcmd = io_cmd;
      end else if (disp) begin
        mv = 1'b0;
      end else if (merr && io_resp_yumi) begin
        mv = 1'b0; merr = 1'b0;
      end
      step();
    end
    io_cmd_v = 1'b0; io_resp_yumi = 1'b0; acc_resp_v = '0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t required below 2000000", $time);
    $fatal(1);
  end

  initial begin
    logic [CW-1:0] c5;
    logic [CW-1:0] errc;
    logic [3:0]    eg [6];

    //           cv    sel   low    ardy   rv     y     rdy   accv   rv    yumi   low    out
    tbl[0]  = '{1'b1, 4'd0, 8'h00, 4'hF, 4'h0, 1'b0, 1'b1, 4'h0, 1'b0, 4'h0, 8'h00, 12'h000};
    tbl[1]  = '{1'b1, 4'd1, 8'h00, 4'hF, 4'h0, 1'b0, 1'b1, 4'h1, 1'b0, 4'h0, 8'h00, 12'h000};
    tbl[2]  = '{1'b1, 4'd2, 8'h00, 4'hF, 4'h0, 1'b0, 1'b1, 4'h2, 1'b0, 4'h0, 8'h00, 12'h001};
    tbl[3]  = '{1'b1, 4'd3, 8'h00, 4'hF, 4'h0, 1'b0, 1'b1, 4'h4, 1'b0, 4'h0, 8'h00, 12'h009};
    tbl[4]  = '{1'b0, 4'd0, 8'h00, 4'hF, 4'h0, 1'b0, 1'b1, 4'h8, 1'b0, 4'h0, 8'h00, 12'h049};
    tbl[5]  = '{1'b0, 4'd0, 8'h00, 4'hF, 4'h0, 1'b0, 1'b1, 4'h0, 1'b0, 4'h0, 8'h00, 12'h249};
    tbl[6]  = '{1'b0, 4'd0, 8'h00, 4'hF, 4'hF, 1'b1, 1'b1, 4'h0, 1'b1, 4'h1, 8'h10, 12'h249};
    tbl[7]  = '{1'b0, 4'd0, 8'h00, 4'hF, 4'hF, 1'b1, 1'b1, 4'h0, 1'b1, 4'h2, 8'h20, 12'h248};
    tbl[8]  = '{1'b0, 4'd0, 8'h00, 4'hF, 4'hF, 1'b1, 1'b1, 4'h0, 1'b1, 4'h4, 8'h30, 12'h240};
    tbl[9]  = '{1'b0, 4'd0, 8'h00, 4'hF, 4'h8, 1'b1, 1'b1, 4'h0, 1'b1, 4'h8, 8'h40, 12'h200};
    tbl[10] = '{1'b0, 4'd0, 8'h00, 4'hF, 4'h0, 1'b0, 1'b1, 4'h0, 1'b0, 4'h0, 8'h00, 12'h000};
    tbl[11] = '{1'b1, 4'd7, 8'h55, 4'hF, 4'h0, 1'b0, 1'b1, 4'h0, 1'b0, 4'h0, 8'h00, 12'h000};
    tbl[12] = '{1'b0, 4'd0, 8'h00, 4'hF, 4'h0, 1'b0, 1'b0, 4'h0, 1'b1, 4'h0, 8'h55, 12'h000};
    tbl[13] = '{1'b0, 4'd0, 8'h00, 4'hF, 4'h0, 1'b1, 1'b0, 4'h0, 1'b1, 4'h0, 8'h55, 12'h000};
    tbl[14] = '{1'b1, 4'd9, 8'h54, 4'hF, 4'h0, 1'b0, 1'b1, 4'h0, 1'b0, 4'h0, 8'h00, 12'h000};
    tbl[15] = '{1'b0, 4'd0, 8'h00, 4'hF, 4'h0, 1'b1, 1'b0, 4'h0, 1'b1, 4'h0, 8'h55, 12'h000};
    tbl[16] = '{1'b0, 4'd0, 8'h00, 4'hF, 4'h0, 1'b0, 1'b1, 4'h0, 1'b0, 4'h0, 8'h00, 12'h000};

    // reset: handshake outputs low even with requests present
    reset_n = 1'b0; io_cmd_v = 1'b1; io_cmd = mk_cmd(4'd0, 8'h00); io_resp_yumi = 1'b0;
    acc_cmd_ready = '1; acc_resp_v = '1; set_fixed_resp();
    #1;
    check("rst ready", CW'(io_cmd_ready), CW'(0));
    check("rst acc_v", CW'(acc_cmd_v), CW'(0));
    check("rst resp_v", CW'(io_resp_v), CW'(0));
    check("rst acc_yumi", CW'(acc_resp_yumi), CW'(0));
    do_reset();
    #1;
    check("rst outstanding", CW'(outstanding), CW'(0));

    // directed vector table
    for (int i = 0; i < 17; i++) begin
      io_cmd_v = tbl[i].cmd_v; io_cmd = mk_cmd(tbl[i].sel, tbl[i].low);
      acc_cmd_ready = tbl[i].ardy; acc_resp_v = tbl[i].rv; io_resp_yumi = tbl[i].yumi;
      #1;
      check($sformatf("tbl%0d ready", i), CW'(io_cmd_ready), CW'(tbl[i].e_ready));
      check($sformatf("tbl%0d acc_v", i), CW'(acc_cmd_v), CW'(tbl[i].e_accv));
      check($sformatf("tbl%0d resp_v", i), CW'(io_resp_v), CW'(tbl[i].e_rv));
      check($sformatf("tbl%0d acc_yumi", i), CW'(acc_resp_yumi), CW'(tbl[i].e_yumi));
      check($sformatf("tbl%0d outstanding", i), CW'(outstanding), CW'(tbl[i].e_out));
      if (tbl[i].e_rv) check($sformatf("tbl%0d resp_low", i), CW'(io_resp[7:0]), CW'(tbl[i].e_low));
      step();
    end

    // counter full on channel 2
    do_reset();
    c5 = '0;
    for (int k = 0; k < 5; k++) begin
      io_cmd_v = 1'b1; io_cmd = mk_cmd(4'd2, 8'(k));
      if (k == 4) c5 = io_cmd;
      #1;
      check($sformatf("full%0d ready", k), CW'(io_cmd_ready), CW'(1));
      check($sformatf("full%0d acc_v", k), CW'(acc_cmd_v), CW'((k == 0) ? 4'h0 : 4'h4));
      step();
    end
    io_cmd_v = 1'b0;
    #1;
    check("full stall acc_v", CW'(acc_cmd_v), CW'(0));
    check("full stall ready", CW'(io_cmd_ready), CW'(0));
    check("full stall cnt2", CW'(cnt_of(2)), CW'(4));
    step();
    acc_resp_v = 4'h4; io_resp_yumi = 1'b1;
    #1;
    check("full yumi acc_yumi", CW'(acc_resp_yumi), CW'(4'h4));
    check("full yumi acc_v", CW'(acc_cmd_v), CW'(0));
    step();
    acc_resp_v = '0; io_resp_yumi = 1'b0;
    #1;
    check("full redispatch acc_v", CW'(acc_cmd_v), CW'(4'h4));
    check("full redispatch cmd", acc_cmd[2*CW +: CW], c5);
    check("full redispatch cnt2", CW'(cnt_of(2)), CW'(3));
    step();
    check("full after cnt2", CW'(cnt_of(2)), CW'(4));
    check("full after acc_v", CW'(acc_cmd_v), CW'(0));

    // round-robin with an error taking cycle 2
    do_reset();
    for (int k = 0; k < 8; k++) begin
      io_cmd_v = 1'b1; io_cmd = mk_cmd(4'(k % 4), 8'h00);
      #1;
      check($sformatf("rr load%0d ready", k), CW'(io_cmd_ready), CW'(1));
      step();
    end
    io_cmd_v = 1'b0;
    step();
    check("rr loaded", CW'(outstanding), CW'(12'h492));
    eg[0] = 4'h1; eg[1] = 4'h2; eg[2] = 4'h0; eg[3] = 4'h4; eg[4] = 4'h8; eg[5] = 4'h1;
    errc = mk_cmd(4'hF, 8'hA6);
    acc_resp_v = '1; io_resp_yumi = 1'b1;
    for (int k = 0; k < 6; k++) begin
      io_cmd_v = (k == 1); io_cmd = errc;
      #1;
      check($sformatf("rr%0d grant", k), CW'(acc_resp_yumi), CW'(eg[k]));
      check($sformatf("rr%0d resp_v", k), CW'(io_resp_v), CW'(1));
      if (k == 2) begin
        check("rr err resp", CW'(io_resp), CW'(errc[RW-1:0] | RW'(1)));
        check("rr err ready", CW'(io_cmd_ready), CW'(0));
      end else begin
        check($sformatf("rr%0d resp_low", k), CW'(io_resp[7:0]),
              CW'((eg[k] == 4'h1) ? 8'h10 : (eg[k] == 4'h2) ? 8'h20 : (eg[k] == 4'h4) ? 8'h30 : 8'h40));
      end
      step();
    end
    acc_resp_v = '0; io_resp_yumi = 1'b0; io_cmd_v = 1'b0;
    #1;
    check("rr counts", CW'(outstanding), CW'(12'h248));

    // simultaneous dispatch and response on channel 1 at count 2
    io_cmd_v = 1'b1; io_cmd = mk_cmd(4'd1, 8'h00);
    step();
    io_cmd = mk_cmd(4'd1, 8'h01);
    step();
    io_cmd_v = 1'b0; acc_resp_v = 4'h2; io_resp_yumi = 1'b1;
    #1;
    check("simul pre cnt1", CW'(cnt_of(1)), CW'(2));
    check("simul acc_v", CW'(acc_cmd_v), CW'(4'h2));
    check("simul acc_yumi", CW'(acc_resp_yumi), CW'(4'h2));
    step();
    acc_resp_v = '0; io_resp_yumi = 1'b0;
    #1;
    check("simul post cnt1", CW'(cnt_of(1)), CW'(2));

    // reset while holding a command on channel 0 with count 3
    do_reset();
    for (int k = 0; k < 4; k++) begin
      io_cmd_v = 1'b1; io_cmd = mk_cmd(4'd0, 8'(k));
      step();
    end
    io_cmd_v = 1'b0; acc_cmd_ready = '0;
    #1;
    check("rsthold cnt0", CW'(cnt_of(0)), CW'(3));
    check("rsthold acc_v", CW'(acc_cmd_v), CW'(4'h1));
    step();
    reset_n = 1'b0; acc_cmd_ready = '1; acc_resp_v = '1;
    #1;
    check("rsthold in-reset ready", CW'(io_cmd_ready), CW'(0));
    check("rsthold in-reset acc_v", CW'(acc_cmd_v), CW'(0));
    check("rsthold in-reset resp_v", CW'(io_resp_v), CW'(0));
    check("rsthold in-reset acc_yumi", CW'(acc_resp_yumi), CW'(0));
    step();
    reset_n = 1'b1; acc_resp_v = '0;
    #1;
    check("rsthold outstanding", CW'(outstanding), CW'(0));
    check("rsthold ready", CW'(io_cmd_ready), CW'(1));
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("rsthold no dispatch%0d", k), CW'(acc_cmd_v), CW'(0));
      step();
    end

    // randomized run against the model
    do_reset();
    run_random(2000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
